// File: rtl/datapath_pkg.sv
// Shared widths, bus-source slot indices and select type for the CPU datapath.
package datapath_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_SRC = 32;
  localparam int unsigned SEL_W   = 5;

  typedef logic [SEL_W-1:0] bus_sel_t;

  localparam bus_sel_t BUS_R0     = 5'd0;
  localparam bus_sel_t BUS_HI     = 5'd16;
  localparam bus_sel_t BUS_LO     = 5'd17;
  localparam bus_sel_t BUS_ZHIGH  = 5'd18;
  localparam bus_sel_t BUS_ZLOW   = 5'd19;
  localparam bus_sel_t BUS_PC     = 5'd20;
  localparam bus_sel_t BUS_MDR    = 5'd21;
  localparam bus_sel_t BUS_INPORT = 5'd22;
  localparam bus_sel_t BUS_CSIGN  = 5'd23;

endpackage

// File: rtl/mdr_reg.sv
// Memory Data Register: bus/memory input mux feeding an enabled register with synchronous active-low clear.
module mdr_reg
  import datapath_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rd,
  input  logic [WIDTH-1:0] bus_data,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mdr_d_c;

  assign mdr_d_c = rd ? mem_data : bus_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= mdr_d_c;
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// Bus-centric CPU datapath: one-hot select encoder, 32:1 bus mux and the MDR.
module cpu_datapath
  import datapath_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      encoder_input,
  input  logic             MDR_enable,
  input  logic             Read,
  input  logic [WIDTH-1:0] MDR_data_in,
  output logic [WIDTH-1:0] MDR_data_out,
  output logic [WIDTH-1:0] bus_data
);

  logic [WIDTH-1:0] C_sign_extended;
  logic [WIDTH-1:0] bus_src [NUM_SRC];
  bus_sel_t         sel;
  logic             sel_valid;

  // Tied off until the IR immediate sign-extension is wired in.
  assign C_sign_extended = '0;

  // Priority encoder: scanning high to low leaves the lowest set bit in sel.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (encoder_input[i]) begin
        sel       = SEL_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

  // Bus source table; reserved slots stay zero until their registers exist.
  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      bus_src[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      bus_src[SEL_W'(int'(BUS_R0) + i)] = '0;
    end
    bus_src[BUS_HI]     = '0;
    bus_src[BUS_LO]     = '0;
    bus_src[BUS_ZHIGH]  = '0;
    bus_src[BUS_ZLOW]   = '0;
    bus_src[BUS_PC]     = '0;
    bus_src[BUS_INPORT] = '0;
    bus_src[BUS_MDR]    = MDR_data_out;
    bus_src[BUS_CSIGN]  = C_sign_extended;
  end

  // An all-zero select must not fall through to slot 0.
  assign bus_data = sel_valid ? bus_src[sel] : '0;

  mdr_reg u_mdr_reg (
    .clk      (clock),
    .rst_n    (clear),
    .en       (MDR_enable),
    .rd       (Read),
    .bus_data (bus_data),
    .mem_data (MDR_data_in),
    .q        (MDR_data_out)
  );

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed vector bench for cpu_datapath: MDR loads, hold, select priority and reset priority.
module tb_cpu_datapath;

  logic        clock;
  logic        clear;
  logic [31:0] encoder_input;
  logic        MDR_enable;
  logic        Read;
  logic [31:0] MDR_data_in;
  logic [31:0] MDR_data_out;
  logic [31:0] bus_data;

  int n_tests;
  int n_fail;

  cpu_datapath dut (
    .clock         (clock),
    .clear         (clear),
    .encoder_input (encoder_input),
    .MDR_enable    (MDR_enable),
    .Read          (Read),
    .MDR_data_in   (MDR_data_in),
    .MDR_data_out  (MDR_data_out),
    .bus_data      (bus_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic [31:0] sel;
    logic        en;
    logic        rd;
    logic [31:0] mdata;
    logic [31:0] exp_mdr;
    logic [31:0] exp_bus;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %08h, expected %08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic [31:0] sel, input logic en,
                       input logic rd, input logic [31:0] mdata);
    clear         = clr;
    encoder_input = sel;
    MDR_enable    = en;
    Read          = rd;
    MDR_data_in   = mdata;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // C_sign_extended is forced to 32'h11111111 for the whole table.
    vecs[0]  = '{1'b1, 32'h0080_0000, 1'b1, 1'b0, 32'h0,         32'h1111_1111, 32'h1111_1111};
    vecs[1]  = '{1'b1, 32'h0020_0000, 1'b0, 1'b0, 32'h0,         32'h1111_1111, 32'h1111_1111};
    vecs[2]  = '{1'b1, 32'h0020_0000, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h0020_0000, 1'b0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h0020_0000, 1'b0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h0020_0000, 1'b0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 32'h00A0_0000, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[8]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[10] = '{1'b1, 32'h0180_0000, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h1111_1111};
    vecs[11] = '{1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[12] = '{1'b1, 32'h0020_0000, 1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[13] = '{1'b0, 32'h0020_0000, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0,         32'h0};
    vecs[14] = '{1'b1, 32'h0020_0000, 1'b1, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[15] = '{1'b1, 32'h8080_0000, 1'b1, 1'b0, 32'h0,         32'h1111_1111, 32'h1111_1111};

    // Reset: two edges with clear low.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_mdr", 0, MDR_data_out, 32'h0);
    check("reset_bus", 0, bus_data, 32'h0);

    force dut.C_sign_extended = 32'h1111_1111;

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      drive(vecs[i].clr, vecs[i].sel, vecs[i].en, vecs[i].rd, vecs[i].mdata);
      @(posedge clock);
      #1;
      check("vec_mdr", i, MDR_data_out, vecs[i].exp_mdr);
      check("vec_bus", i, bus_data, vecs[i].exp_bus);
    end

    // Enable pulsed and data wiggled strictly between edges must not load MDR.
    @(negedge clock);
    drive(1'b1, 32'h0020_0000, 1'b0, 1'b1, 32'hAAAA_5555);
    #1 MDR_enable = 1'b1;
    #1 Read = 1'b0;
    #1 MDR_enable = 1'b0;
    @(posedge clock);
    #1;
    check("glitch_hold_mdr", 0, MDR_data_out, 32'h1111_1111);

    // Bus follows select combinationally, mid-cycle.
    encoder_input = 32'h0;
    #1;
    check("comb_bus_zero", 0, bus_data, 32'h0);
    encoder_input = 32'h00E0_0000;
    #1;
    check("comb_bus_mdr", 0, bus_data, 32'h1111_1111);

    // Memory load then immediate bus visibility via slot 21.
    @(negedge clock);
    drive(1'b1, 32'h0020_0000, 1'b1, 1'b1, 32'h0BAD_F00D);
    @(posedge clock);
    #1;
    check("memload_mdr", 0, MDR_data_out, 32'h0BAD_F00D);
    check("memload_bus", 0, bus_data, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
